logic_oracle_responder: RTL and testbench

Responder for the CPU's external logic-engine handshake (`logic_req`/`logic_addr` → `logic_ack`/`logic_data`). It serves each request from a small programmable result table after a configurable latency, returning one result per request level. It sits beside `thiele_cpu` in simulation and FPGA top levels in place of a real logic engine, so benches and bring-up can exercise deterministic oracle results and stall behaviour.

---
 rtl/thiele_logic_pkg.sv | 18 +
 rtl/logic_resp_table.sv | 34 +++
 rtl/logic_oracle_responder.sv | 172 +++++++++++++++++
 tb/tb_logic_oracle_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/thiele_logic_pkg.sv
// thiele_logic_pkg: types and constants shared by the logic-engine oracle responder.
package thiele_logic_pkg;

  // Handshake FSM states of the responder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } logic_resp_state_t;

  // Data returned for addresses beyond the result table.
  localparam logic [31:0] LOGIC_MISS_DATA_DEFAULT = 32'hFFFF_FFFF;

  // Width of the programmable latency and of the wait counter.
  localparam int LOGIC_LAT_W = 8;

endpackage

// File: rtl/logic_resp_table.sv
// logic_resp_table: TABLE_DEPTH x DATA_W result register file, one write port,
// one combinational read port, all entries cleared by reset.
module logic_resp_table
  import thiele_logic_pkg::*;
#(
  parameter int TABLE_DEPTH = 16,
  parameter int DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [$clog2(TABLE_DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [$clog2(TABLE_DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [TABLE_DEPTH];

  // Write port: a write becomes visible only after its edge, so a same-edge
  // read still sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logic_oracle_responder.sv
// logic_oracle_responder: stands in for the external logic engine. Each request
// level is answered once from a programmable table after cfg_latency wait cycles.
// Build option: define LOGIC_ORACLE_STATS_EN to add saturating statistics counters
// (served_count, miss_count, abort_count, stall_cycles).
module logic_oracle_responder
  import thiele_logic_pkg::*;
#(
  parameter int                TABLE_DEPTH = 16,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] MISS_DATA   = DATA_W'(LOGIC_MISS_DATA_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           logic_req,
  input  logic [DATA_W-1:0]              logic_addr,
  output logic                           logic_ack,
  output logic [DATA_W-1:0]              logic_data,
  input  logic [LOGIC_LAT_W-1:0]         cfg_latency,
  input  logic                           tbl_we,
  input  logic [$clog2(TABLE_DEPTH)-1:0] tbl_addr,
  input  logic [DATA_W-1:0]              tbl_wdata,
  output logic                           busy,
  output logic                           miss
`ifdef LOGIC_ORACLE_STATS_EN
  ,
  output logic [31:0]                    served_count,
  output logic [31:0]                    miss_count,
  output logic [31:0]                    abort_count,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int AW = $clog2(TABLE_DEPTH);

  logic_resp_state_t       state_q, state_d;
  logic [LOGIC_LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]       res_data_p0, res_data_d;
  logic                    res_miss_p0, res_miss_d;
  logic                    ack_d, miss_d;
  logic [DATA_W-1:0]       data_d;
  logic                    ack_vld_p1, miss_p1;
  logic [DATA_W-1:0]       data_p1;
  logic                    addr_hit;
  logic [AW-1:0]           rd_idx;
  logic [DATA_W-1:0]       tbl_rdata;

  assign addr_hit = (logic_addr < DATA_W'(TABLE_DEPTH));
  assign rd_idx   = logic_addr[AW-1:0];

  logic_resp_table #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .DATA_W      (DATA_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (tbl_wdata),
    .raddr (rd_idx),
    .rdata (tbl_rdata)
  );

  // Next-state and output decode; outputs default to idle values every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_p0;
    res_miss_d = res_miss_p0;
    ack_d      = 1'b0;
    data_d     = '0;
    miss_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (logic_req) begin
          res_data_d = addr_hit ? tbl_rdata : MISS_DATA;
          res_miss_d = !addr_hit;
          cnt_d      = cfg_latency;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!logic_req) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ACK;
          ack_d   = 1'b1;
          data_d  = res_data_p0;
          miss_d  = res_miss_p0;
        end
      end
      ACK: begin
        state_d = logic_req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!logic_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control stage: FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture stage (p0): result and miss flag latched at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_p0 <= '0;
      res_miss_p0 <= 1'b0;
    end else begin
      res_data_p0 <= res_data_d;
      res_miss_p0 <= res_miss_d;
    end
  end

  // Output stage (p1): registered ack pulse with its data and miss flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_vld_p1 <= 1'b0;
      data_p1    <= '0;
      miss_p1    <= 1'b0;
    end else begin
      ack_vld_p1 <= ack_d;
      data_p1    <= data_d;
      miss_p1    <= miss_d;
    end
  end

  assign logic_ack  = ack_vld_p1;
  assign logic_data = data_p1;
  assign miss       = miss_p1;
  assign busy       = (state_q != IDLE);

`ifdef LOGIC_ORACLE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? (val + 32'd1) : val;
  endfunction

  logic in_wait, abort_evt;
  assign in_wait   = (state_q == WAIT);
  assign abort_evt = in_wait && !logic_req;

  // Statistics stage: counters advance on the same edge as the event they count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_count <= '0;
      miss_count   <= '0;
      abort_count  <= '0;
      stall_cycles <= '0;
    end else begin
      served_count <= sat_inc(served_count, ack_d);
      miss_count   <= sat_inc(miss_count, ack_d && res_miss_p0);
      abort_count  <= sat_inc(abort_count, abort_evt);
      stall_cycles <= sat_inc(stall_cycles, in_wait);
    end
  end
`endif

endmodule

// File: tb/tb_logic_oracle_responder.sv
// tb_logic_oracle_responder: directed vector table, hand-written reset sequence and
// randomized transactions checked against a transaction-level model of the responder.
module tb_logic_oracle_responder;

  localparam int TABLE_DEPTH = 16;
  localparam int DATA_W      = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              logic_req;
  logic [DATA_W-1:0] logic_addr;
  logic              logic_ack;
  logic [DATA_W-1:0] logic_data;
  logic [7:0]        cfg_latency;
  logic              tbl_we;
  logic [3:0]        tbl_addr;
  logic [DATA_W-1:0] tbl_wdata;
  logic              busy;
  logic              miss;
`ifdef LOGIC_ORACLE_STATS_EN
  logic [31:0] served_count, miss_count, abort_count, stall_cycles;
`endif

  always #5 clk = ~clk;

  logic_oracle_responder #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .DATA_W      (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .logic_req   (logic_req),
    .logic_addr  (logic_addr),
    .logic_ack   (logic_ack),
    .logic_data  (logic_data),
    .cfg_latency (cfg_latency),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_wdata   (tbl_wdata),
    .busy        (busy),
    .miss        (miss)
`ifdef LOGIC_ORACLE_STATS_EN
    ,
    .served_count (served_count),
    .miss_count   (miss_count),
    .abort_count  (abort_count),
    .stall_cycles (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: table contents plus event tallies.
  logic [31:0] mdl_tbl [TABLE_DEPTH];
  int m_served, m_miss, m_abort, m_stall;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          hold;
    int          gap;
    logic        we;
    logic [3:0]  widx;
    logic [31:0] wdata;
    int          exp_k;
    logic [31:0] exp_data;
    logic        exp_miss;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TABLE_DEPTH; i++) mdl_tbl[i] = '0;
    m_served = 0;
    m_miss   = 0;
    m_abort  = 0;
    m_stall  = 0;
  endtask

  // One request: req high for H edges starting at the capture edge, then low for G.
  // The ack is due after edge L+1 when the level survives that long.
  task automatic drive_txn(input string tag, input logic [31:0] addr, input int L,
                           input int H, input int G, input bit use_model, input bit rnd_wr,
                           input logic cap_we, input logic [3:0] cap_idx,
                           input logic [31:0] cap_data, input int exp_k_in,
                           input logic [31:0] exp_data_in, input logic exp_miss_in);
    int          exp_k;
    logic [31:0] exp_d;
    logic        exp_m;
    int          acks;
    exp_k = exp_k_in;
    exp_d = exp_data_in;
    exp_m = exp_miss_in;
    if (use_model) begin
      exp_k = (H >= L + 2) ? L + 1 : -1;
      exp_m = (addr >= 32'(TABLE_DEPTH));
      exp_d = exp_m ? 32'hFFFF_FFFF : mdl_tbl[addr[3:0]];
    end
    if (exp_k >= 0) begin
      m_served++;
      if (exp_m) m_miss++;
      m_stall += L + 1;
    end else begin
      m_abort++;
      m_stall += H;
    end
    acks = 0;
    for (int k = 0; k < H + G; k++) begin
      logic_req   = (k < H);
      logic_addr  = addr;
      cfg_latency = (k == 0) ? 8'(L) : 8'($urandom);
      if (rnd_wr) begin
        tbl_we    = 1'($urandom_range(0, 1));
        tbl_addr  = 4'($urandom);
        tbl_wdata = $urandom;
      end else if (k == 0) begin
        tbl_we    = cap_we;
        tbl_addr  = cap_idx;
        tbl_wdata = cap_data;
      end else begin
        tbl_we = 1'b0;
      end
      if (tbl_we) mdl_tbl[tbl_addr] = tbl_wdata;
      @(posedge clk);
      #1;
      tbl_we = 1'b0;
      if (logic_ack) acks++;
      chk($sformatf("%s ack k=%0d", tag, k), 32'(logic_ack), 32'(k == exp_k));
      chk($sformatf("%s data k=%0d", tag, k), logic_data, (k == exp_k) ? exp_d : 32'd0);
      chk($sformatf("%s miss k=%0d", tag, k), 32'(miss), 32'((k == exp_k) && exp_m));
      chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(k < H));
    end
    chk($sformatf("%s ack count", tag), 32'(acks), (exp_k >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int          rl, rh, rg;
    logic [31:0] exp_v;

    // addr, L, H, G, we, widx, wdata, exp_k, exp_data, exp_miss
    vecs[0]  = '{32'd3,  2,   10,  1, 1'b0, 4'd0, 32'd0,  3,   32'd41,        1'b0};
    vecs[1]  = '{32'd20, 0,   3,   1, 1'b0, 4'd0, 32'd0,  1,   32'hFFFF_FFFF, 1'b1};
    vecs[2]  = '{32'd3,  0,   22,  1, 1'b0, 4'd0, 32'd0,  1,   32'd41,        1'b0};
    vecs[3]  = '{32'd5,  1,   4,   1, 1'b0, 4'd0, 32'd0,  2,   32'd18,        1'b0};
    vecs[4]  = '{32'd3,  4,   2,   1, 1'b0, 4'd0, 32'd0,  -1,  32'd0,         1'b0};
    vecs[5]  = '{32'd3,  4,   5,   1, 1'b0, 4'd0, 32'd0,  -1,  32'd0,         1'b0};
    vecs[6]  = '{32'd7,  1,   4,   1, 1'b1, 4'd7, 32'd34, 2,   32'd0,         1'b0};
    vecs[7]  = '{32'd7,  0,   2,   1, 1'b0, 4'd0, 32'd0,  1,   32'd34,        1'b0};
    vecs[8]  = '{32'd15, 0,   2,   1, 1'b0, 4'd0, 32'd0,  1,   32'd0,         1'b0};
    vecs[9]  = '{32'd16, 3,   5,   2, 1'b0, 4'd0, 32'd0,  4,   32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{32'h8000_0005, 0, 2, 1, 1'b0, 4'd0, 32'd0, 1, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{32'd3,  255, 257, 1, 1'b0, 4'd0, 32'd0,  256, 32'd41,        1'b0};

    rst_n       = 1'b0;
    logic_req   = 1'b0;
    logic_addr  = '0;
    cfg_latency = '0;
    tbl_we      = 1'b0;
    tbl_addr    = '0;
    tbl_wdata   = '0;
    model_reset();

    #12;
    chk("reset ack", 32'(logic_ack), 32'd0);
    chk("reset data", logic_data, 32'd0);
    chk("reset miss", 32'(miss), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preload table entries used by the directed vectors.
    tbl_we = 1'b1; tbl_addr = 4'd3; tbl_wdata = 32'd41; mdl_tbl[3] = 32'd41;
    @(posedge clk);
    #1;
    tbl_addr = 4'd5; tbl_wdata = 32'd18; mdl_tbl[5] = 32'd18;
    @(posedge clk);
    #1;
    tbl_we = 1'b0;

    for (int v = 0; v < 12; v++) begin
      drive_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].lat, vecs[v].hold,
                vecs[v].gap, 1'b0, 1'b0, vecs[v].we, vecs[v].widx, vecs[v].wdata,
                vecs[v].exp_k, vecs[v].exp_data, vecs[v].exp_miss);
    end

    // Randomized transactions with random table traffic on every edge.
    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h10) : 32'($urandom_range(0, 15));
      rl = $urandom_range(0, 6);
      rh = $urandom_range(1, rl + 4);
      rg = $urandom_range(1, 3);
      drive_txn($sformatf("rnd%0d", t), ra, rl, rh, rg, 1'b1, 1'b1,
                1'b0, 4'd0, 32'd0, 0, 32'd0, 1'b0);
    end

`ifdef LOGIC_ORACLE_STATS_EN
    chk("served_count", served_count, 32'(m_served));
    chk("miss_count", miss_count, 32'(m_miss));
    chk("abort_count", abort_count, 32'(m_abort));
    chk("stall_cycles", stall_cycles, 32'(m_stall));
`endif

    // Reset asserted while the ack pulse is on the outputs.
    exp_v       = mdl_tbl[3];
    logic_req   = 1'b1;
    logic_addr  = 32'd3;
    cfg_latency = 8'd2;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset ack", 32'(logic_ack), 32'd1);
    chk("pre-reset data", logic_data, exp_v);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset ack", 32'(logic_ack), 32'd0);
    chk("async reset data", logic_data, 32'd0);
    chk("async reset miss", 32'(miss), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    logic_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-reset ack c=%0d", c), 32'(logic_ack), 32'd0);
      chk($sformatf("post-reset busy c=%0d", c), 32'(busy), 32'd0);
    end
    // Table was cleared by reset: entry 3 now reads 0.
    drive_txn("post-reset read", 32'd3, 0, 2, 1, 1'b1, 1'b0,
              1'b0, 4'd0, 32'd0, 0, 32'd0, 1'b0);

`ifdef LOGIC_ORACLE_STATS_EN
    chk("served_count after reset", served_count, 32'(m_served));
    chk("abort_count after reset", abort_count, 32'(m_abort));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
